commit_trace: RTL and testbench



---
 rtl/trace_pkg.sv | 26 ++
 rtl/trace_fifo.sv | 59 +++++
 rtl/commit_trace.sv | 189 ++++++++++++++++++
 tb/tb_commit_trace.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared constants, serializer states and record sizing helpers for the commit trace unit.
package trace_pkg;

    localparam logic [7:0] TRACE_HDR = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_t;

    // Packed record is {step, pc, rd_byte, data}.
    function automatic int rec_width(input int step_w, input int pc_w, input int data_w);
        return step_w + pc_w + 8 + data_w;
    endfunction

    // Bytes on the wire per record: header plus every record byte.
    function automatic int rec_bytes(input int step_w, input int pc_w, input int data_w);
        return 1 + rec_width(step_w, pc_w, data_w) / 8;
    endfunction

    function automatic logic [7:0] rd_byte(input logic we, input logic [5:0] rd);
        return {we, 1'b0, rd};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is taken only with a same-cycle pop.
module trace_fifo #(
    parameter int WIDTH = 104,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == (AW+1)'(DEPTH));
    assign empty  = (count_r == {(AW+1){1'b0}});
    assign pop_s  = pop && !empty;
    assign push_s = push && (!full || pop_s);
    assign rdata  = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; when full, the slot being popped is the one overwritten.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/commit_trace.sv
// Retire counter, window capture into a FIFO, and a framed byte serializer with valid/ready back-pressure.
module commit_trace
    import trace_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int STEP_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic [PC_W-1:0]   cfg_pc_min,
    input  logic [STEP_W-1:0] cfg_step_lo,
    input  logic [STEP_W-1:0] cfg_step_hi,
    input  logic              retire_valid,
    input  logic [PC_W-1:0]   retire_pc,
    input  logic              retire_we,
    input  logic [5:0]        retire_rd,
    input  logic [DATA_W-1:0] retire_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [STEP_W-1:0] step_count,
    output logic [15:0]       drop_count,
    output logic              overflow,
    output logic              done
);

    localparam int REC_W      = rec_width(STEP_W, PC_W, DATA_W);
    localparam int REC_BYTES  = rec_bytes(STEP_W, PC_W, DATA_W);
    localparam int BODY_BYTES = REC_BYTES - 1;
    localparam int IDX_W      = $clog2(BODY_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BODY_BYTES - 1);

    logic [STEP_W-1:0] step_count_r;
    logic [15:0]       drop_count_r;
    logic              overflow_r;
    logic              done_r;

    state_t            state_r;
    state_t            state_s;
    logic              tx_valid_r;
    logic              tx_valid_s;
    logic [7:0]        tx_data_r;
    logic [7:0]        tx_data_s;
    logic [REC_W-1:0]  rec_r;
    logic [REC_W-1:0]  rec_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_s;

    logic              counted_s;
    logic [STEP_W-1:0] step_next_s;
    logic              capture_s;
    logic              drop_s;
    logic [DATA_W-1:0] data_in_s;
    logic [REC_W-1:0]  rec_in_s;
    logic              pop_s;
    logic [REC_W-1:0]  fifo_rdata_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    assign counted_s   = enable && retire_valid && (retire_pc >= cfg_pc_min);
    assign step_next_s = (step_count_r == {STEP_W{1'b1}}) ? step_count_r
                                                         : step_count_r + {{(STEP_W-1){1'b0}}, 1'b1};
    assign capture_s   = counted_s && (step_next_s >= cfg_step_lo) && (step_next_s <= cfg_step_hi);
    assign data_in_s   = retire_we ? retire_data : {DATA_W{1'b0}};
    assign rec_in_s    = {step_next_s, retire_pc, rd_byte(retire_we, retire_rd), data_in_s};
    assign drop_s      = capture_s && fifo_full_s && !pop_s;

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (capture_s),
        .wdata (rec_in_s),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Retire counting, drop accounting and completion flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            step_count_r <= {STEP_W{1'b0}};
            drop_count_r <= 16'h0000;
            overflow_r   <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            if (counted_s) begin
                step_count_r <= step_next_s;
            end
            if (drop_s && (drop_count_r != 16'hFFFF)) begin
                drop_count_r <= drop_count_r + 16'd1;
            end
            overflow_r <= overflow_r | drop_s;
            done_r     <= (step_count_r > cfg_step_hi) && fifo_empty_s && (state_r == IDLE);
        end
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= IDLE;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            rec_r      <= {REC_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
        end else begin
            state_r    <= state_s;
            tx_valid_r <= tx_valid_s;
            tx_data_r  <= tx_data_s;
            rec_r      <= rec_s;
            idx_r      <= idx_s;
        end
    end

    // Serializer next state: the record is shifted MSB-first so the top byte is always next.
    always_comb begin
        state_s    = state_r;
        tx_valid_s = tx_valid_r;
        tx_data_s  = tx_data_r;
        rec_s      = rec_r;
        idx_s      = idx_r;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    state_s    = HDR;
                    tx_valid_s = 1'b1;
                    tx_data_s  = TRACE_HDR;
                    rec_s      = fifo_rdata_s;
                end else begin
                    tx_valid_s = 1'b0;
                end
            end
            HDR: begin
                if (tx_ready) begin
                    state_s   = BODY;
                    tx_data_s = rec_r[REC_W-1 -: 8];
                    rec_s     = {rec_r[REC_W-9:0], 8'h00};
                    idx_s     = {IDX_W{1'b0}};
                end else begin
                    state_s = HDR;
                end
            end
            BODY: begin
                if (tx_ready) begin
                    if (idx_r == LAST_IDX) begin
                        if (!fifo_empty_s) begin
                            pop_s      = 1'b1;
                            state_s    = HDR;
                            tx_valid_s = 1'b1;
                            tx_data_s  = TRACE_HDR;
                            rec_s      = fifo_rdata_s;
                        end else begin
                            state_s    = IDLE;
                            tx_valid_s = 1'b0;
                            tx_data_s  = 8'h00;
                        end
                    end else begin
                        idx_s     = idx_r + IDX_W'(1'b1);
                        tx_data_s = rec_r[REC_W-1 -: 8];
                        rec_s     = {rec_r[REC_W-9:0], 8'h00};
                    end
                end else begin
                    state_s = BODY;
                end
            end
            default: begin
                state_s    = IDLE;
                tx_valid_s = 1'b0;
                tx_data_s  = 8'h00;
            end
        endcase
    end

    assign tx_data    = tx_data_r;
    assign tx_valid   = tx_valid_r;
    assign step_count = step_count_r;
    assign drop_count = drop_count_r;
    assign overflow   = overflow_r;
    assign done       = done_r;

endmodule

// File: tb/tb_commit_trace.sv
// Scoreboard bench for commit_trace: stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_commit_trace;

    localparam int PC_W   = 32;
    localparam int DATA_W = 32;
    localparam int STEP_W = 32;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rstn;
    logic              enable;
    logic [PC_W-1:0]   cfg_pc_min;
    logic [STEP_W-1:0] cfg_step_lo;
    logic [STEP_W-1:0] cfg_step_hi;
    logic              retire_valid;
    logic [PC_W-1:0]   retire_pc;
    logic              retire_we;
    logic [5:0]        retire_rd;
    logic [DATA_W-1:0] retire_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [STEP_W-1:0] step_count;
    logic [15:0]       drop_count;
    logic              overflow;
    logic              done;

    logic [7:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    commit_trace #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W),
        .STEP_W (STEP_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .cfg_pc_min   (cfg_pc_min),
        .cfg_step_lo  (cfg_step_lo),
        .cfg_step_hi  (cfg_step_hi),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_we    (retire_we),
        .retire_rd    (retire_rd),
        .retire_data  (retire_data),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .step_count   (step_count),
        .drop_count   (drop_count),
        .overflow     (overflow),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected frame: A5, step, pc, {we,0,rd}, data (zero when no write), all big-endian.
    task automatic push_rec(input logic [31:0] s, input logic [31:0] pc, input logic we,
                            input logic [5:0] rd, input logic [31:0] data);
        logic [31:0] d;
        d = we ? data : 32'h0;
        exp_q.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) exp_q.push_back(s[8*i +: 8]);
        for (int i = 3; i >= 0; i--) exp_q.push_back(pc[8*i +: 8]);
        exp_q.push_back({we, 1'b0, rd});
        for (int i = 3; i >= 0; i--) exp_q.push_back(d[8*i +: 8]);
    endtask

    task automatic retire(input logic [31:0] pc, input logic we, input logic [5:0] rd,
                          input logic [31:0] data);
        retire_valid = 1'b1;
        retire_pc    = pc;
        retire_we    = we;
        retire_rd    = rd;
        retire_data  = data;
        tick();
        retire_valid = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        exp_q.delete();
        rstn = 1'b1;
    endtask

    // Run until every expected byte has been consumed, optionally toggling tx_ready, then idle to catch extras.
    task automatic drain(input string name, input int budget, input bit toggle);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            if (toggle) tx_ready = ~tx_ready;
            tick();
            n++;
        end
        tx_ready = 1'b1;
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (20) tick();
    endtask

    // Monitor: every accepted byte is compared to the queue head; stalled bytes must hold.
    initial begin
        logic       stall;
        logic [7:0] held;
        stall = 1'b0;
        held  = 8'h00;
        forever begin
            @(negedge clk);
            if (stall && rstn) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, held);
            end
            stall = 1'b0;
            if (rstn && tx_valid) begin
                if (tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got 0x%02h, no byte expected", tx_data);
                    end else begin
                        check("tx_byte", tx_data, exp_q.pop_front());
                    end
                end else begin
                    stall = 1'b1;
                    held  = tx_data;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] fmt_vec [14];
        fmt_vec = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h08,
                    8'hA1, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

        rstn = 1'b0; enable = 1'b0; tx_ready = 1'b0;
        cfg_pc_min = 32'h0; cfg_step_lo = 32'h0; cfg_step_hi = 32'h0;
        retire_valid = 1'b0; retire_pc = 32'h0; retire_we = 1'b0;
        retire_rd = 6'd0; retire_data = 32'h0;
        repeat (3) tick();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_step", step_count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_done", done, 0);
        rstn = 1'b1;
        tick();

        // Window: pc 0x100 is below pc_min, step 4 is past hi; record 2 is the hand-built format vector.
        cfg_pc_min = 32'h104; cfg_step_lo = 32'd1; cfg_step_hi = 32'd3;
        enable = 1'b1; tx_ready = 1'b1;
        push_rec(32'd1, 32'h104, 1'b0, 6'd5, 32'h12345678);
        for (int i = 0; i < 14; i++) exp_q.push_back(fmt_vec[i]);
        push_rec(32'd3, 32'h10C, 1'b0, 6'd5, 32'h12345678);
        retire(32'h100, 1'b0, 6'd5, 32'h12345678);
        retire(32'h104, 1'b0, 6'd5, 32'h12345678);
        retire(32'h108, 1'b1, 6'd33, 32'hDEADBEEF);
        retire(32'h10C, 1'b0, 6'd5, 32'h12345678);
        retire(32'h110, 1'b1, 6'd7, 32'h00000055);
        check("win_step", step_count, 4);
        drain("win_drain", 300, 1'b1);
        check("win_done", done, 1);
        check("win_drop", drop_count, 0);
        check("win_overflow", overflow, 0);

        // Overflow: one record sits in the serializer, 16 fill the FIFO, steps 18..21 are dropped.
        do_reset();
        cfg_pc_min = 32'h0; cfg_step_lo = 32'd1; cfg_step_hi = 32'd100;
        tx_ready = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            retire(32'h200 + 32'(4*i), 1'b1, 6'(i), 32'(i) * 32'h01010101);
            if (i <= 17) push_rec(32'(i), 32'h200 + 32'(4*i), 1'b1, 6'(i), 32'(i) * 32'h01010101);
        end
        check("ovf_step", step_count, 21);
        check("ovf_drop", drop_count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_not_done", done, 0);
        // Release: header accepted on edge 1, 13 body bytes on edges 2..14; edge 14 pops while full.
        tx_ready = 1'b1;
        repeat (13) tick();
        retire(32'h300, 1'b1, 6'd2, 32'hCAFEF00D);
        push_rec(32'd22, 32'h300, 1'b1, 6'd2, 32'hCAFEF00D);
        check("fullpop_drop", drop_count, 4);
        check("fullpop_step", step_count, 22);
        drain("ovf_drain", 18*14 + 100, 1'b0);

        // Reset while byte 6 of a frame is on the wire.
        do_reset();
        cfg_pc_min = 32'h0; cfg_step_lo = 32'd1; cfg_step_hi = 32'd5;
        tx_ready = 1'b1;
        push_rec(32'd1, 32'h400, 1'b1, 6'd10, 32'h11223344);
        retire(32'h400, 1'b1, 6'd10, 32'h11223344);
        tick();
        repeat (6) tick();
        check("mid_valid", tx_valid, 1);
        check("mid_queue_left", exp_q.size(), 8);
        rstn = 1'b0;
        tx_ready = 1'b0;
        tick();
        exp_q.delete();
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_step", step_count, 0);
        check("mid_rst_drop", drop_count, 0);
        check("mid_rst_overflow", overflow, 0);
        rstn = 1'b1;
        tx_ready = 1'b1;
        repeat (20) tick();
        check("post_rst_valid", tx_valid, 0);
        check("post_rst_done", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
